// File: rtl/cvo_ctrl_pkg.sv
// Shared definitions for the CVO mode control block: register addresses,
// field widths, the apply-FSM state type and the mode bundle.
package cvo_ctrl_pkg;

    localparam int H_W = 14;
    localparam int V_W = 13;

    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_STATUS     = 4'd1;
    localparam logic [3:0] ADDR_IRQ        = 4'd2;
    localparam logic [3:0] ADDR_USEDW      = 4'd3;
    localparam logic [3:0] ADDR_H_ACTIVE   = 4'd4;
    localparam logic [3:0] ADDR_V_ACTIVE   = 4'd5;
    localparam logic [3:0] ADDR_H_TOTAL    = 4'd6;
    localparam logic [3:0] ADDR_V_TOTAL    = 4'd7;
    localparam logic [3:0] ADDR_INTERLACED = 4'd8;
    localparam logic [3:0] ADDR_COMMIT     = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_APPLY
    } mode_state_t;

    typedef struct packed {
        logic [H_W-1:0] h_active;
        logic [V_W-1:0] v_active;
        logic [H_W-1:0] h_total;
        logic [V_W-1:0] v_total;
        logic           interlaced;
    } mode_t;

    // Build the power-on mode from integer parameters; always progressive.
    function automatic mode_t reset_mode(input int ha, input int va, input int ht, input int vt);
        mode_t m;
        m.h_active   = H_W'(ha);
        m.v_active   = V_W'(va);
        m.h_total    = H_W'(ht);
        m.v_total    = V_W'(vt);
        m.interlaced = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/cvo_mode_shadow.sv
// Apply FSM: holds a committed mode request until a frame boundary (or until
// the output is disabled) and then copies the staged mode to the live outputs.
module cvo_mode_shadow
    import cvo_ctrl_pkg::*;
#(
    parameter int H_ACTIVE_PIXELS = 1920,
    parameter int V_ACTIVE_LINES  = 1080,
    parameter int H_TOTAL_PIXELS  = 2200,
    parameter int V_TOTAL_LINES   = 1125
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  commit_set,
    input  logic  commit_clr,
    input  logic  vid_sof,
    input  logic  enable,
    input  mode_t staging,
    output mode_t active,
    output logic  mode_change,
    output logic  pending,
    output logic  busy
);

    localparam mode_t RESET_MODE =
        reset_mode(H_ACTIVE_PIXELS, V_ACTIVE_LINES, H_TOTAL_PIXELS, V_TOTAL_LINES);

    mode_state_t state_q, state_d;
    mode_t       active_q, active_d;
    logic        load;

    // State and live-mode registers; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            active_q <= RESET_MODE;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    // Next state; the copy is taken on the edge into APPLY so the new mode and
    // the mode_change pulse appear together. A cancel beats a coincident vid_sof.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit_set) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (commit_clr) begin
                    state_d = ST_IDLE;
                end else if (vid_sof || !enable) begin
                    state_d = ST_APPLY;
                    load    = 1'b1;
                end
            end
            ST_APPLY: begin
                state_d = commit_set ? ST_PENDING : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Live mode follows the staging registers only on an accepted apply.
    always_comb begin
        active_d = load ? staging : active_q;
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        mode_change = (state_q == ST_APPLY);
        pending     = (state_q == ST_PENDING);
        busy        = (state_q != ST_IDLE);
    end

    assign active = active_q;

endmodule

// File: rtl/cvo_mode_control.sv
// CVO mode control: Avalon-MM register file, staging registers, interrupt
// logic and FIFO-underflow clear handshake around the mode apply FSM.
module cvo_mode_control
    import cvo_ctrl_pkg::*;
#(
    parameter int H_ACTIVE_PIXELS  = 1920,
    parameter int V_ACTIVE_LINES   = 1080,
    parameter int H_TOTAL_PIXELS   = 2200,
    parameter int V_TOTAL_LINES    = 1125,
    parameter int USED_WORDS_WIDTH = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  av_address,
    input  logic                        av_read,
    output logic [15:0]                 av_readdata,
    input  logic                        av_write,
    input  logic [15:0]                 av_writedata,
    input  logic [USED_WORDS_WIDTH-1:0] usedw,
    input  logic                        underflow_sticky,
    input  logic                        vid_sof,
    input  logic                        is_output_active,
    output logic                        enable,
    output logic                        clear_underflow_sticky,
    output logic [13:0]                 h_active,
    output logic [12:0]                 v_active,
    output logic [13:0]                 h_total,
    output logic [12:0]                 v_total,
    output logic                        interlaced,
    output logic                        mode_change,
    output logic                        status_update_int
);

    localparam mode_t RESET_MODE =
        reset_mode(H_ACTIVE_PIXELS, V_ACTIVE_LINES, H_TOTAL_PIXELS, V_TOTAL_LINES);

    logic [2:0] ctrl_q, ctrl_d;          // [0] enable, [1] mode irq en, [2] underflow irq en
    mode_t      stage_q, stage_d;
    logic [1:0] irq_q, irq_d;            // [0] mode, [1] underflow
    logic       uf_prev_q, uf_prev_d;
    logic       clr_uf_q, clr_uf_d;

    logic  commit_set, commit_clr;
    logic  set_mode, set_uf, clr_mode, clr_uf_irq;
    logic  pending, busy;
    mode_t active;

    // Reads have no side effects and two writedata bits are never stored.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, av_read, av_writedata[15:14]};

    assign commit_set = av_write && (av_address == ADDR_COMMIT) &&  av_writedata[0];
    assign commit_clr = av_write && (av_address == ADDR_COMMIT) && !av_writedata[0];

    cvo_mode_shadow #(
        .H_ACTIVE_PIXELS (H_ACTIVE_PIXELS),
        .V_ACTIVE_LINES  (V_ACTIVE_LINES),
        .H_TOTAL_PIXELS  (H_TOTAL_PIXELS),
        .V_TOTAL_LINES   (V_TOTAL_LINES)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .commit_set  (commit_set),
        .commit_clr  (commit_clr),
        .vid_sof     (vid_sof),
        .enable      (ctrl_q[0]),
        .staging     (stage_q),
        .active      (active),
        .mode_change (mode_change),
        .pending     (pending),
        .busy        (busy)
    );

    // Register file state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            stage_q   <= RESET_MODE;
            irq_q     <= '0;
            uf_prev_q <= 1'b0;
            clr_uf_q  <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            stage_q   <= stage_d;
            irq_q     <= irq_d;
            uf_prev_q <= uf_prev_d;
            clr_uf_q  <= clr_uf_d;
        end
    end

    // Write decode, interrupt set/clear (set wins, disable masks) and the
    // underflow-clear request that holds until the FIFO flag is seen low.
    always_comb begin
        ctrl_d  = ctrl_q;
        stage_d = stage_q;
        if (av_write) begin
            case (av_address)
                ADDR_CTRL:       ctrl_d             = av_writedata[2:0];
                ADDR_H_ACTIVE:   stage_d.h_active   = av_writedata[H_W-1:0];
                ADDR_V_ACTIVE:   stage_d.v_active   = av_writedata[V_W-1:0];
                ADDR_H_TOTAL:    stage_d.h_total    = av_writedata[H_W-1:0];
                ADDR_V_TOTAL:    stage_d.v_total    = av_writedata[V_W-1:0];
                ADDR_INTERLACED: stage_d.interlaced = av_writedata[0];
                default: ;
            endcase
        end

        set_mode   = mode_change && ctrl_q[1];
        set_uf     = underflow_sticky && !uf_prev_q && ctrl_q[2];
        clr_mode   = av_write && (av_address == ADDR_IRQ) && av_writedata[1];
        clr_uf_irq = av_write && (av_address == ADDR_IRQ) && av_writedata[2];
        irq_d[0]   = ((irq_q[0] && !clr_mode)   || set_mode) && ctrl_d[1];
        irq_d[1]   = ((irq_q[1] && !clr_uf_irq) || set_uf)   && ctrl_d[2];
        uf_prev_d  = underflow_sticky;

        clr_uf_d = clr_uf_q;
        if (av_write && (av_address == ADDR_STATUS) && av_writedata[1]) begin
            clr_uf_d = 1'b1;
        end else if (!underflow_sticky) begin
            clr_uf_d = 1'b0;
        end
    end

    // Combinational readback, zero-extended to the bus width.
    always_comb begin
        av_readdata = '0;
        case (av_address)
            ADDR_CTRL:       av_readdata = {13'd0, ctrl_q};
            ADDR_STATUS:     av_readdata = {13'd0, pending, underflow_sticky, is_output_active};
            ADDR_IRQ:        av_readdata = {13'd0, irq_q[1], irq_q[0], 1'b0};
            ADDR_USEDW:      av_readdata = 16'(usedw);
            ADDR_H_ACTIVE:   av_readdata = 16'(stage_q.h_active);
            ADDR_V_ACTIVE:   av_readdata = 16'(stage_q.v_active);
            ADDR_H_TOTAL:    av_readdata = 16'(stage_q.h_total);
            ADDR_V_TOTAL:    av_readdata = 16'(stage_q.v_total);
            ADDR_INTERLACED: av_readdata = {15'd0, stage_q.interlaced};
            ADDR_COMMIT:     av_readdata = {15'd0, busy};
            default:         av_readdata = '0;
        endcase
    end

    assign enable                 = ctrl_q[0];
    assign clear_underflow_sticky = clr_uf_q;
    assign h_active               = active.h_active;
    assign v_active               = active.v_active;
    assign h_total                = active.h_total;
    assign v_total                = active.v_total;
    assign interlaced             = active.interlaced;
    assign status_update_int      = |irq_q;

endmodule

// File: tb/tb_cvo_mode_control.sv
// Bench for cvo_mode_control: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_cvo_mode_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  av_address;
    logic        av_read;
    logic [15:0] av_readdata;
    logic        av_write;
    logic [15:0] av_writedata;
    logic [14:0] usedw;
    logic        underflow_sticky;
    logic        vid_sof;
    logic        is_output_active;
    logic        enable;
    logic        clear_underflow_sticky;
    logic [13:0] h_active;
    logic [12:0] v_active;
    logic [13:0] h_total;
    logic [12:0] v_total;
    logic        interlaced;
    logic        mode_change;
    logic        status_update_int;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    cvo_mode_control #(
        .H_ACTIVE_PIXELS  (1920),
        .V_ACTIVE_LINES   (1080),
        .H_TOTAL_PIXELS   (2200),
        .V_TOTAL_LINES    (1125),
        .USED_WORDS_WIDTH (15)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .av_address             (av_address),
        .av_read                (av_read),
        .av_readdata            (av_readdata),
        .av_write               (av_write),
        .av_writedata           (av_writedata),
        .usedw                  (usedw),
        .underflow_sticky       (underflow_sticky),
        .vid_sof                (vid_sof),
        .is_output_active       (is_output_active),
        .enable                 (enable),
        .clear_underflow_sticky (clear_underflow_sticky),
        .h_active               (h_active),
        .v_active               (v_active),
        .h_total                (h_total),
        .v_total                (v_total),
        .interlaced             (interlaced),
        .mode_change            (mode_change),
        .status_update_int      (status_update_int)
    );

    // ---------------- behavioural model ----------------
    int stg[16];          // staged field per register address
    int act[16];          // live field per register address
    int m_ctrl;
    int m_phase;          // 0 no request, 1 waiting for frame, 2 applying now
    bit m_irq_mode, m_irq_uf, m_prev, m_clr;

    function automatic int fmask(int a);
        case (a)
            4, 6:    return 'h3FFF;
            5, 7:    return 'h1FFF;
            8:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_update(bit r, bit w, int a, int d, bit sof, bit st);
        int  nctrl, nphase;
        bit  clr_m, clr_u;
        if (r) begin
            stg[4] = 1920; stg[5] = 1080; stg[6] = 2200; stg[7] = 1125; stg[8] = 0;
            for (int i = 4; i <= 8; i++) act[i] = stg[i];
            m_ctrl = 0; m_phase = 0;
            m_irq_mode = 0; m_irq_uf = 0; m_prev = 0; m_clr = 0;
            return;
        end
        nphase = m_phase;
        if (m_phase == 0) begin
            nphase = (w && a == 9 && (d & 1) != 0) ? 1 : 0;
        end else if (m_phase == 1) begin
            if (w && a == 9 && (d & 1) == 0) nphase = 0;
            else if (sof || (m_ctrl & 1) == 0) begin
                nphase = 2;
                for (int i = 4; i <= 8; i++) act[i] = stg[i];
            end
        end else begin
            nphase = (w && a == 9 && (d & 1) != 0) ? 1 : 0;
        end
        if (w && a >= 4 && a <= 8) stg[a] = d & fmask(a);
        nctrl = (w && a == 0) ? (d & 7) : m_ctrl;
        clr_m = w && a == 2 && (d & 2) != 0;
        clr_u = w && a == 2 && (d & 4) != 0;
        m_irq_mode = ((m_irq_mode && !clr_m) || (m_phase == 2 && (m_ctrl & 2) != 0)) && (nctrl & 2) != 0;
        m_irq_uf   = ((m_irq_uf && !clr_u) || (st && !m_prev && (m_ctrl & 4) != 0)) && (nctrl & 4) != 0;
        m_prev = st;
        if (w && a == 1 && (d & 2) != 0) m_clr = 1;
        else if (!st) m_clr = 0;
        m_ctrl  = nctrl;
        m_phase = nphase;
    endtask

    function automatic int exp_rd(int a);
        case (a)
            0:       return m_ctrl;
            1:       return ((m_phase == 1) ? 4 : 0) + (underflow_sticky ? 2 : 0) + (is_output_active ? 1 : 0);
            2:       return (m_irq_uf ? 4 : 0) + (m_irq_mode ? 2 : 0);
            3:       return int'(usedw);
            4, 5, 6, 7, 8: return stg[a];
            9:       return (m_phase != 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
        tot_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("enable",       32'(enable),                 32'(m_ctrl & 1));
            cmp("mode_change",  32'(mode_change),            32'(m_phase == 2));
            cmp("h_active",     32'(h_active),               32'(act[4]));
            cmp("v_active",     32'(v_active),               32'(act[5]));
            cmp("h_total",      32'(h_total),                32'(act[6]));
            cmp("v_total",      32'(v_total),                32'(act[7]));
            cmp("interlaced",   32'(interlaced),             32'(act[8]));
            cmp("irq",          32'(status_update_int),      32'(m_irq_mode | m_irq_uf));
            cmp("clear_uf",     32'(clear_underflow_sticky), 32'(m_clr));
            cmp("readdata",     32'(av_readdata),            32'(exp_rd(int'(av_address))));
        end
    end

    // One clock: sample the driven inputs, advance the model, settle past negedge.
    task automatic tick();
        bit r, w, sof, st;
        int a, d;
        r = rst; w = av_write; a = int'(av_address); d = int'(av_writedata);
        sof = vid_sof; st = underflow_sticky;
        @(posedge clk);
        model_update(r, w, a, d, sof, st);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(int a, int d);
        av_write = 1'b1; av_address = 4'(a); av_writedata = 16'(d);
        tick();
        av_write = 1'b0;
    endtask

    task automatic rd_chk(string name, int a, int want);
        av_address = 4'(a);
        #1;
        cmp(name, 32'(av_readdata), 32'(want));
    endtask

    initial begin
        rst = 1'b1; av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
        usedw = '0; underflow_sticky = 1'b0; vid_sof = 1'b0; is_output_active = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Reset values
        rd_chk("rd_h_active_reset", 4, 1920);
        rd_chk("rd_h_total_reset", 6, 2200);
        cmp("h_active_reset", 32'(h_active), 1920);
        cmp("v_active_reset", 32'(v_active), 1080);
        cmp("h_total_reset",  32'(h_total), 2200);
        cmp("v_total_reset",  32'(v_total), 1125);
        cmp("interlaced_reset", 32'(interlaced), 0);
        cmp("enable_reset", 32'(enable), 0);

        // Enabled: apply waits for vid_sof
        wr(0, 1); wr(4, 1280); wr(5, 720); wr(6, 1650); wr(7, 750); wr(9, 1);
        tick(); tick();
        cmp("h_active_held", 32'(h_active), 1920);
        cmp("no_change_before_sof", 32'(mode_change), 0);
        vid_sof = 1'b1; tick(); vid_sof = 1'b0;
        cmp("h_active_applied", 32'(h_active), 1280);
        cmp("v_active_applied", 32'(v_active), 720);
        cmp("h_total_applied",  32'(h_total), 1650);
        cmp("v_total_applied",  32'(v_total), 750);
        cmp("mode_change_pulse", 32'(mode_change), 1);
        tick();
        cmp("mode_change_one_cycle", 32'(mode_change), 0);

        // Disabled: apply without vid_sof, two cycles after the commit write
        wr(0, 0); wr(4, 800); wr(9, 1);
        cmp("disabled_pending_no_pulse", 32'(mode_change), 0);
        rd_chk("status_pending", 1, 4);
        tick();
        cmp("disabled_apply_pulse", 32'(mode_change), 1);
        cmp("disabled_h_active", 32'(h_active), 800);
        tick();

        // Cancel before vid_sof
        wr(0, 1); wr(9, 1); wr(4, 640); wr(9, 0);
        vid_sof = 1'b1; tick(); vid_sof = 1'b0;
        cmp("cancel_no_pulse", 32'(mode_change), 0);
        tick();
        cmp("cancel_no_pulse2", 32'(mode_change), 0);
        cmp("cancel_h_active_kept", 32'(h_active), 800);

        // Underflow interrupt: set, clear, set-beats-clear, disable clears
        wr(0, 7);
        underflow_sticky = 1'b1; tick();
        cmp("uf_irq_set", 32'(status_update_int), 1);
        wr(2, 4);
        cmp("uf_irq_cleared", 32'(status_update_int), 0);
        underflow_sticky = 1'b0; tick();
        underflow_sticky = 1'b1; wr(2, 4);
        cmp("uf_irq_set_wins", 32'(status_update_int), 1);
        rd_chk("irq_reg", 2, 4);
        wr(0, 1);
        cmp("uf_irq_disable_clears", 32'(status_update_int), 0);

        // Underflow clear handshake
        wr(1, 2);
        cmp("clear_uf_asserted", 32'(clear_underflow_sticky), 1);
        tick();
        cmp("clear_uf_held", 32'(clear_underflow_sticky), 1);
        underflow_sticky = 1'b0; tick();
        cmp("clear_uf_dropped", 32'(clear_underflow_sticky), 0);

        // Reset while pending discards the request
        wr(9, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        cmp("reset_pending_no_pulse", 32'(mode_change), 0);
        vid_sof = 1'b1; tick(); vid_sof = 1'b0;
        cmp("reset_pending_no_apply", 32'(mode_change), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 399) == 0);
            av_write         = ($urandom_range(0, 2) == 0);
            av_address       = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            av_writedata     = 16'($urandom);
            av_read          = $urandom_range(0, 1) == 1;
            vid_sof          = ($urandom_range(0, 7) == 0);
            is_output_active = $urandom_range(0, 1) == 1;
            usedw            = 15'($urandom);
            if ($urandom_range(0, 9) == 0) underflow_sticky = ~underflow_sticky;
            tick();
        end
        rst = 1'b0; av_write = 1'b0; vid_sof = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
